// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } pll_state_e;

  localparam int unsigned RETRY_W = 3;
  localparam int unsigned LOSS_W  = 8;

  // Width of the shared state timer: must hold the largest of the three intervals.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous bit, async active-low clear.
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock supervisor on the free-running refclk.
// Optional macro LOCK_LOSS_CNT_EN builds the saturating lock-loss counter.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned POR_CYCLES   = 125,
  parameter int unsigned LOCK_TIMEOUT = 125000,
  parameter int unsigned LOCK_STABLE  = 1250,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned MAX_RETRY    = 7
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              soft_reset,
  output logic              pll_rst,
  output logic              sys_rst_n,
  output logic              ready,
  output logic              retry_fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [LOSS_W-1:0]  lock_loss_cnt
);

  localparam int unsigned CNT_W = cnt_width(POR_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);

  pll_state_e         r_state;
  pll_state_e         w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [RETRY_W-1:0] r_retry_cnt;
  logic [RETRY_W-1:0] w_retry_next;
  logic               w_locked_s;
  logic               r_pll_rst;
  logic               r_sys_rst_n;
  logic               r_ready;
  logic               r_retry_fail;

  bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .i_clk   (refclk),
    .i_rst_n (rst_n),
    .i_d     (pll_locked),
    .o_q     (w_locked_s)
  );

  always_comb begin
    w_next       = r_state;
    w_retry_next = r_retry_cnt;
    case (r_state)
      PLL_RST: begin
        if (r_cnt == CNT_W'(POR_CYCLES - 1)) w_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (soft_reset) begin
          w_next = PLL_RST;
        end else if (w_locked_s) begin
          w_next = STABLE;
        end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          w_retry_next = (r_retry_cnt == '1) ? r_retry_cnt : r_retry_cnt + RETRY_W'(1);
          w_next       = (32'(w_retry_next) >= MAX_RETRY) ? FAIL : PLL_RST;
        end
      end
      STABLE: begin
        if (soft_reset)                             w_next = PLL_RST;
        else if (!w_locked_s)                       w_next = WAIT_LOCK;
        else if (r_cnt == CNT_W'(LOCK_STABLE - 1))  w_next = RUN;
      end
      RUN: begin
        if (soft_reset || !w_locked_s) w_next = PLL_RST;
      end
      FAIL: begin
        if (soft_reset) begin
          w_next       = PLL_RST;
          w_retry_next = '0;
        end
      end
      default: w_next = PLL_RST;
    endcase
    if (w_next == RUN) w_retry_next = '0;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= PLL_RST;
      r_cnt        <= '0;
      r_retry_cnt  <= '0;
      r_pll_rst    <= 1'b1;
      r_sys_rst_n  <= 1'b0;
      r_ready      <= 1'b0;
      r_retry_fail <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_retry_cnt <= w_retry_next;
      // Timer restarts on every state change and parks at all-ones otherwise.
      if (w_next != r_state)  r_cnt <= '0;
      else if (r_cnt != '1)   r_cnt <= r_cnt + CNT_W'(1);
      r_pll_rst    <= (w_next == PLL_RST) || (w_next == FAIL);
      r_sys_rst_n  <= (w_next == RUN);
      r_ready      <= (w_next == RUN);
      r_retry_fail <= (w_next == FAIL);
    end
  end

`ifdef LOCK_LOSS_CNT_EN
  logic              w_loss_inc;
  logic [LOSS_W-1:0] r_lock_loss_cnt;

  // soft_reset wins over a simultaneous lock loss, so that cycle is not counted.
  assign w_loss_inc = (r_state == RUN) && !soft_reset && !w_locked_s;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)                                   r_lock_loss_cnt <= '0;
    else if (w_loss_inc && r_lock_loss_cnt != '1) r_lock_loss_cnt <= r_lock_loss_cnt + LOSS_W'(1);
  end

  assign lock_loss_cnt = r_lock_loss_cnt;
`else
  assign lock_loss_cnt = '0;
`endif

  assign pll_rst    = r_pll_rst;
  assign sys_rst_n  = r_sys_rst_n;
  assign ready      = r_ready;
  assign retry_fail = r_retry_fail;
  assign retry_cnt  = r_retry_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer (small timing parameters).
module tb_pll_reset_sequencer;

  logic       refclk     = 1'b0;
  logic       rst_n      = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_reset = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       retry_fail;
  logic [2:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic [6:0] w_outs;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned losses   = 0;

  always #4 refclk = ~refclk;

  pll_reset_sequencer #(
    .POR_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .LOCK_STABLE  (8),
    .SYNC_STAGES  (2),
    .MAX_RETRY    (3)
  ) dut (
    .refclk        (refclk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .soft_reset    (soft_reset),
    .pll_rst       (pll_rst),
    .sys_rst_n     (sys_rst_n),
    .ready         (ready),
    .retry_fail    (retry_fail),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt)
  );

  // {pll_rst, sys_rst_n, ready, retry_fail, retry_cnt}
  assign w_outs = {pll_rst, sys_rst_n, ready, retry_fail, retry_cnt};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int unsigned n;
    n = 0;
    while (!ready && n < 200) begin
      tick(1);
      n++;
    end
    if (n >= 200) check(tag, ready, 1);
  endtask

  function automatic logic [7:0] loss_exp(input int unsigned n);
`ifdef LOCK_LOSS_CNT_EN
    return (n > 255) ? 8'd255 : 8'(n);
`else
    return 8'd0;
`endif
  endfunction

  initial begin
    logic [6:0] exp;
    int unsigned m;

    #10;
    check("reset_outs", w_outs, 7'b1000_000);
    check("reset_loss", lock_loss_cnt, 0);
    @(posedge refclk); #1;
    rst_n = 1'b1;

    // Repeated timeouts with no lock: 4 high / 20 low, third timeout enters FAIL.
    for (int unsigned k = 1; k <= 72; k++) begin
      tick(1);
      m = k % 24;
      if (k == 72) exp = 7'b1001_011;
      else         exp = {(m < 4) ? 1'b1 : 1'b0, 3'b000, 3'(k / 24)};
      check($sformatf("timeout_k%0d", k), w_outs, exp);
    end
    tick(10);
    check("fail_hold", w_outs, 7'b1001_011);

    // soft_reset out of FAIL.
    soft_reset = 1'b1; tick(1); soft_reset = 1'b0;
    check("soft_fail", w_outs, 7'b1000_000);
    tick(3);
    check("soft_fail_por_hi", pll_rst, 1);
    tick(1);
    check("soft_fail_por_lo", pll_rst, 0);
    tick(20);
    check("retry1", w_outs, 7'b1000_001);
    tick(4);
    check("retry1_wait", w_outs, 7'b0000_001);

    // Lock glitch at STABLE count 5, then fresh lock.
    pll_locked = 1'b1;
    tick(8);
    pll_locked = 1'b0;
    tick(3);
    check("glitch_no_run", w_outs, 7'b0000_001);
    pll_locked = 1'b1;
    tick(10);
    check("lock_t10", w_outs, 7'b0000_001);
    tick(1);
    check("lock_t11_run", w_outs, 7'b0110_000);

    // Lock loss in RUN.
    pll_locked = 1'b0;
    tick(2);
    check("loss_t2", w_outs, 7'b0110_000);
    tick(1);
    losses++;
    check("loss_t3", w_outs, 7'b1000_000);
    check("loss_cnt1", lock_loss_cnt, loss_exp(losses));
    tick(3);
    check("loss_por_hi", pll_rst, 1);
    tick(1);
    check("loss_por_lo", w_outs, 7'b0000_000);
    pll_locked = 1'b1;
    tick(11);
    check("relock_run", w_outs, 7'b0110_000);

    // soft_reset in RUN.
    soft_reset = 1'b1; tick(1); soft_reset = 1'b0;
    check("soft_run", w_outs, 7'b1000_000);
    check("soft_run_loss", lock_loss_cnt, loss_exp(losses));
    tick(1);
    wait_ready("soft_run_relock");

    // soft_reset coincident with lock loss; then a soft_reset during PLL_RST.
    pll_locked = 1'b0;
    tick(2);
    soft_reset = 1'b1; tick(1); soft_reset = 1'b0;
    check("prio_outs", w_outs, 7'b1000_000);
    check("prio_loss", lock_loss_cnt, loss_exp(losses));
    pll_locked = 1'b1;
    tick(1);
    soft_reset = 1'b1; tick(1); soft_reset = 1'b0;
    tick(1);
    check("por_soft_hi", pll_rst, 1);
    tick(1);
    check("por_soft_lo", pll_rst, 0);
    wait_ready("prio_relock");

    // Lock-loss saturation.
    for (int unsigned i = 0; i < 260; i++) begin
      pll_locked = 1'b0; tick(1); pll_locked = 1'b1;
      tick(3);
      losses++;
      wait_ready("sat_relock");
      if (i == 199) check("loss_cnt_mid", lock_loss_cnt, loss_exp(losses));
    end
    check("loss_cnt_sat", lock_loss_cnt, loss_exp(losses));

    // Async reset mid-STABLE.
    pll_locked = 1'b0; tick(1); pll_locked = 1'b1;
    tick(10);
    check("mid_stable", w_outs, 7'b0000_000);
    #2 rst_n = 1'b0;
    #1;
    check("async_outs", w_outs, 7'b1000_000);
    check("async_loss", lock_loss_cnt, 0);
    tick(2);
    check("async_hold", w_outs, 7'b1000_000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
